// File: rtl/button_event_pkg.sv
// Shared definitions for the push-button event controller: register map,
// debounce cell state encoding and default counter width.
package button_event_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd1;
    localparam logic [1:0] ADDR_EDGE     = 2'd2;
    localparam logic [1:0] ADDR_DEBOUNCE = 2'd3;

    localparam int DEFAULT_CNT_W = 20;

    typedef enum logic {
        IDLE,
        CNT
    } db_state_t;

endpackage

// File: rtl/button_debounce_cell.sv
// One-bit synchroniser plus debounce FSM. The stable level only follows the
// synchronised input after it has held its new value for reload+1 counts.
module button_debounce_cell
    import button_event_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_raw,
    input  logic [CNT_W-1:0] i_reload,
    output logic             o_stable,
    output logic             o_rise,
    output logic             o_fall
);

    logic [1:0]       r_sync;
    logic             r_stable;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stable_nxt;

    assign w_s = r_sync[1];

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, matching real hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_stable <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
        end else begin
            r_sync   <= {r_sync[0], i_raw};
            r_stable <= w_stable_nxt;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        o_rise       = 1'b0;
        o_fall       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s != r_stable) begin
                    w_state_nxt = CNT;
                    w_cnt_nxt   = i_reload;
                end
            end
            CNT: begin
                if (w_s == r_stable) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Commit: pulses are combinational so capture lands on
                    // the same edge that updates the stable level.
                    w_stable_nxt = w_s;
                    o_rise       = w_s;
                    o_fall       = ~w_s;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/button_event_ctrl.sv
// Avalon-MM push-button controller: debounce, sticky edge capture, maskable irq.
// Define BUTTON_EVENT_BOTH_EDGES_EN to also capture releases.
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int WIDTH            = 3,
    parameter int CNT_W            = DEFAULT_CNT_W,
    parameter int DEFAULT_DEBOUNCE = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

`ifdef BUTTON_EVENT_BOTH_EDGES_EN
    localparam logic CAPTURE_RISE = 1'b1;
`else
    localparam logic CAPTURE_RISE = 1'b0;
`endif

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [CNT_W-1:0] r_reload;

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rdata;
    logic             w_unused;

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        button_debounce_cell #(
            .CNT_W (CNT_W)
        ) u_cell (
            .clk      (clk),
            .reset    (reset),
            .i_raw    (in_port[g]),
            .i_reload (r_reload),
            .o_stable (w_stable[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

    assign w_set = w_fall | (w_rise & {WIDTH{CAPTURE_RISE}});
    assign w_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask   <= '0;
            r_edge   <= '0;
            r_reload <= CNT_W'(DEFAULT_DEBOUNCE);
        end else begin
            if (write && address == ADDR_MASK)
                r_mask <= writedata[WIDTH-1:0];
            if (write && address == ADDR_DEBOUNCE)
                r_reload <= writedata[CNT_W-1:0];
            // Set is OR-ed in after the clear so a coincident press survives.
            r_edge <= (r_edge & ~w_clr) | w_set;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:     w_rdata[WIDTH-1:0] = w_stable;
            ADDR_MASK:     w_rdata[WIDTH-1:0] = r_mask;
            ADDR_EDGE:     w_rdata[WIDTH-1:0] = r_edge;
            ADDR_DEBOUNCE: w_rdata[CNT_W-1:0] = r_reload;
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= w_rdata;
    end

    assign irq = |(r_edge & r_mask);

    // Reads have no side effects and the upper write bits map to nothing.
    assign w_unused = &{1'b0, read, writedata[31:CNT_W]};

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed self-checking bench for button_event_ctrl; expected values are
// hand-derived from the debounce timing (stable updates R+4 edges after input).
module tb_button_event_ctrl;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_MASK = 2'd1;
    localparam logic [1:0] A_EDGE = 2'd2;
    localparam logic [1:0] A_DEB  = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [2:0]  in_port = 3'b111;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    button_event_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick();
        write     = 1'b0;
        writedata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        read    = 1'b1;
        tick();
        d       = readdata;
        read    = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        // Reset and idle
        tick();
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (irq !== 1'b0) check("idle_irq", {31'd0, irq}, 32'd0);
        end
        check("idle_irq_end", {31'd0, irq}, 32'd0);
        bus_read(A_DATA, rd);  check("rst_data", rd, 32'h7);
        bus_read(A_EDGE, rd);  check("rst_edge", rd, 32'h0);
        bus_read(A_MASK, rd);  check("rst_mask", rd, 32'h0);
        bus_read(A_DEB, rd);   check("rst_deb", rd, 32'd50000);

        // Glitch on bit 1, reload 4, all bits unmasked
        bus_write(A_DEB, 32'd4);
        bus_write(A_MASK, 32'h7);
        address = A_DATA;
        in_port = 3'b101;
        tick(); tick(); tick();
        in_port = 3'b111;
        for (int i = 0; i < 12; i++) tick();
        check("glitch_irq", {31'd0, irq}, 32'd0);
        bus_read(A_DATA, rd);  check("glitch_data", rd, 32'h7);
        bus_read(A_EDGE, rd);  check("glitch_edge", rd, 32'h0);

        // Press bit 0: irq exactly on edge 8, DATA readback one edge later
        bus_write(A_MASK, 32'h1);
        address = A_DATA;
        in_port = 3'b110;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check($sformatf("press_irq_e%0d", k), {31'd0, irq}, (k >= 8) ? 32'd1 : 32'd0);
            check($sformatf("press_data_e%0d", k), readdata, (k >= 9) ? 32'h6 : 32'h7);
        end
        bus_read(A_EDGE, rd);  check("press_edge", rd, 32'h1);

        // Press bit 2, then W1C
        in_port = 3'b010;
        for (int i = 0; i < 10; i++) tick();
        bus_read(A_EDGE, rd);  check("edge_0x5", rd, 32'h5);
        bus_write(A_MASK, 32'h5);
        check("irq_mask5", {31'd0, irq}, 32'd1);
        bus_write(A_EDGE, 32'h1);
        check("w1c1_irq", {31'd0, irq}, 32'd1);
        bus_read(A_EDGE, rd);  check("w1c1_edge", rd, 32'h4);
        bus_write(A_EDGE, 32'h4);
        check("w1c4_irq", {31'd0, irq}, 32'd0);
        bus_read(A_EDGE, rd);  check("w1c4_edge", rd, 32'h0);

        // Release bit 0
        in_port = 3'b011;
        for (int i = 0; i < 10; i++) tick();
        bus_read(A_DATA, rd);  check("release_data", rd, 32'h3);
        bus_read(A_EDGE, rd);
`ifdef BUTTON_EVENT_BOTH_EDGES_EN
        check("release_edge", rd, 32'h1);
        bus_write(A_EDGE, 32'h1);
`else
        check("release_edge", rd, 32'h0);
`endif
        check("release_irq_clr", {31'd0, irq}, 32'd0);

        // New press of bit 0 commits on edge 8; W1C lands on the same edge
        in_port = 3'b010;
        for (int i = 0; i < 7; i++) tick();
        check("coinc_pre_irq", {31'd0, irq}, 32'd0);
        bus_write(A_EDGE, 32'h1);
        check("coinc_irq", {31'd0, irq}, 32'd1);
        bus_read(A_EDGE, rd);  check("coinc_edge", rd, 32'h1);

        // Reset mid-count: release bit 0, assert reset when cnt = 2
        in_port = 3'b011;
        for (int i = 0; i < 5; i++) tick();
        check("midcnt_irq_before", {31'd0, irq}, 32'd1);
        reset = 1'b1;
        #1;
        check("midcnt_irq", {31'd0, irq}, 32'd0);
        check("midcnt_readdata", readdata, 32'd0);
        in_port = 3'b111;
        tick(); tick();
        reset = 1'b0;
        bus_read(A_DATA, rd);  check("post_data", rd, 32'h7);
        bus_read(A_EDGE, rd);  check("post_edge", rd, 32'h0);
        bus_read(A_MASK, rd);  check("post_mask", rd, 32'h0);
        bus_read(A_DEB, rd);   check("post_deb", rd, 32'd50000);
        check("post_irq", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
